// File: rtl/fifo_pack_pkg.sv
// Shared types and defaults for the FIFO word packer.
package fifo_pack_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } pack_state_e;

  localparam int PACK_WIDTH = 8;
  localparam int PACK_LANES = 4;

endpackage

// File: rtl/fifo_word_packer.sv
// Drains a registered-read FIFO and packs LANES consecutive entries into one
// word, with flush support for partial words and a valid/ready output.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int WIDTH = PACK_WIDTH,
  parameter int LANES = PACK_LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [WIDTH-1:0]           fifo_rd_data,
  output logic                       fifo_pop,
  input  logic                       flush,
  output logic [WIDTH*LANES-1:0]     out_data,
  output logic [$clog2(LANES+1)-1:0] out_count,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int CW = $clog2(LANES+1);
  localparam logic [CW-1:0] FULL = CW'(LANES);

  pack_state_e            state;
  logic [CW-1:0]          issued;
  logic [CW-1:0]          captured;
  logic [CW-1:0]          captured_next;
  logic                   pend;
  logic                   flush_req;
  logic                   flush_pending;
  logic                   go_full;
  logic                   go_flush;
  logic                   accept;
  logic [WIDTH-1:0]       lane_q [LANES];
  logic [WIDTH*LANES-1:0] lanes_next;

  always_comb begin
    flush_pending = flush_req | flush;
    fifo_pop      = !rst && (state == COLLECT) && !fifo_empty &&
                    (issued < FULL) && !flush_pending;
    captured_next = captured + CW'(pend);
    go_full       = (state == COLLECT) && (captured_next == FULL);
    // Flush waits until any in-flight byte has landed in its lane.
    go_flush      = (state == COLLECT) && flush_pending &&
                    (captured != '0) && !pend;
    accept        = (state == OUTPUT) && out_valid && out_ready;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam logic [CW-1:0] IDX = CW'(g);
    logic hit;
    assign hit = pend && (captured == IDX);
    // Next-lane view lets the final capture and the word load share one edge.
    assign lanes_next[g*WIDTH +: WIDTH] = hit ? fifo_rd_data : lane_q[g];

    always_ff @(posedge clk) begin
      if (rst || accept) begin
        lane_q[g] <= '0;
      end else if (hit) begin
        lane_q[g] <= fifo_rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      issued    <= '0;
      captured  <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          pend     <= fifo_pop;
          captured <= captured_next;
          if (fifo_pop) begin
            issued <= issued + CW'(1);
          end
          if (flush && ((captured != '0) || pend)) begin
            flush_req <= 1'b1;
          end
          if (go_full || go_flush) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            out_data  <= lanes_next;
            out_count <= captured_next;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            issued    <= '0;
            captured  <= '0;
            flush_req <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer fed by a behavioural 8-deep byte FIFO.
module tb_fifo_word_packer;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int CW = $clog2(L+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           fifo_empty = 1'b1;
  logic [W-1:0]   fifo_rd_data = '0;
  logic           fifo_pop;
  logic           flush = 1'b0;
  logic [W*L-1:0] out_data;
  logic [CW-1:0]  out_count;
  logic           out_valid;
  logic           out_ready = 1'b1;

  fifo_word_packer #(.WIDTH(W), .LANES(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_pop     (fifo_pop),
    .flush        (flush),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Byte FIFO: registered read data, empty flag updated at the clock edge.
  logic       push_en = 1'b0;
  logic [7:0] push_data = '0;
  logic [7:0] fq[$];
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pop) begin
      if (fq.size() == 0) check("pop_on_empty", 32'd1, 32'd0);
      else fifo_rd_data <= fq.pop_front();
    end
    if (push_en && fq.size() < 8) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
  end

  logic [31:0] got_data[$];
  int          got_count[$];
  int          pop_log[$];
  int          rise_log[$];
  int          hs_log[$];
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_pop) pop_log.push_back(cyc);
      if (out_valid && !prev_valid) rise_log.push_back(cyc);
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_count.push_back(int'(out_count));
        hs_log.push_back(cyc);
      end
    end
    prev_valid <= out_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    push_en   = 1'b1;
    push_data = d;
    tick(1);
    push_en   = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_count.delete();
    pop_log.delete();
    rise_log.delete();
    hs_log.delete();
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (got_data.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("word_arrival", got_data.size(), n);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  function automatic logic [31:0] word_at(input int i);
    return (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int count_at(input int i);
    return (i < got_count.size()) ? got_count[i] : -1;
  endfunction

  initial begin
    int fcyc;
    int npre;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [31:0] w;

    // Reset behaviour with a non-empty FIFO: no pops while rst is high.
    tick(1);
    for (int i = 0; i < 4; i++) push(8'(i));
    @(negedge clk);
    check("rst_pop", fifo_pop, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", out_count, 0);
    @(posedge clk); #1;
    clear_logs();
    rst = 1'b0;
    wait_words(1, 40);
    check("t1_data", word_at(0), 32'h0302_0100);
    check("t1_count", count_at(0), 4);
    check("t1_pops", pop_log.size(), 4);
    check("t1_pop_run", at(pop_log, 3) - at(pop_log, 0), 3);
    check("t1_latency", at(rise_log, 0) - at(pop_log, 0), L + 1);
    tick(5);
    check("t1_one_pulse", got_data.size(), 1);
    check("t1_fifo_empty", fifo_empty, 1);

    // Backpressure: word held, pops stop at LANES; then throughput check.
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    tick(12);
    check("t2_pops_held", pop_log.size(), 4);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 32'h1312_1110);
    check("t2_count", out_count, 4);
    check("t2_no_hs", got_data.size(), 0);
    tick(5);
    check("t2_data_stable", out_data, 32'h1312_1110);
    out_ready = 1'b1;
    wait_words(2, 40);
    check("t2_w0", word_at(0), 32'h1312_1110);
    check("t2_w1", word_at(1), 32'h1716_1514);
    check("t2_c1", count_at(1), 4);
    check("t2_turnaround", at(rise_log, 1) - at(hs_log, 0), L + 2);
    tick(3);

    // Flush after both bytes have been captured.
    clear_logs();
    push(8'hA1);
    push(8'hA2);
    tick(2);
    fcyc = cyc;
    pulse_flush();
    wait_words(1, 30);
    check("t3_data", word_at(0), 32'h0000_A2A1);
    check("t3_count", count_at(0), 2);
    check("t3_pops", pop_log.size(), 2);
    check("t3_latency", at(rise_log, 0) - fcyc, 1);
    tick(3);

    // Flush while the second capture is still in flight; third byte waits.
    clear_logs();
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    fcyc = cyc;
    pulse_flush();
    wait_words(1, 30);
    check("t4_data", word_at(0), 32'h0000_A2A1);
    check("t4_count", count_at(0), 2);
    check("t4_latency", at(rise_log, 0) - fcyc, 2);
    npre = 0;
    foreach (pop_log[i]) if (pop_log[i] <= at(hs_log, 0)) npre++;
    check("t4_pops_suppressed", npre, 2);
    tick(4);
    pulse_flush();
    wait_words(2, 30);
    check("t4_tail_data", word_at(1), 32'h0000_00A3);
    check("t4_tail_count", count_at(1), 1);
    tick(3);

    // Flush with an empty accumulator, and flush during OUTPUT: both ignored.
    clear_logs();
    tick(3);
    pulse_flush();
    tick(10);
    check("t5_idle_words", got_data.size(), 0);
    check("t5_idle_valid", out_valid, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hB0 + i));
    for (int k = 0; k < 30 && !out_valid; k++) tick(1);
    check("t5_out_valid", out_valid, 1);
    pulse_flush();
    tick(3);
    check("t5_out_data", out_data, 32'hB3B2_B1B0);
    check("t5_out_count", out_count, 4);
    out_ready = 1'b1;
    wait_words(1, 20);
    push(8'hC0);
    tick(12);
    check("t5_no_spurious", got_data.size(), 1);
    pulse_flush();
    wait_words(2, 20);
    check("t5_c0_data", word_at(1), 32'h0000_00C0);
    check("t5_c0_count", count_at(1), 1);
    tick(3);

    // Reset mid-word discards captured bytes.
    clear_logs();
    push(8'h55);
    push(8'h66);
    tick(4);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_count", out_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    wait_words(1, 30);
    check("t6_data", word_at(0), 32'h2322_2120);
    check("t6_count", count_at(0), 4);
    tick(3);

    // Random traffic: output must be the pushed byte stream in groups of LANES.
    clear_logs();
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(0, 99) < 70);
      if (fq.size() < 7 && $urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push_en   = 1'b1;
        push_data = b;
      end else begin
        push_en = 1'b0;
      end
      tick(1);
    end
    push_en = 1'b0;
    while (exp_q.size() % L != 0) begin
      if (fq.size() < 7) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
      end else begin
        tick(1);
      end
    end
    out_ready = 1'b1;
    wait_words(exp_q.size() / L, 600);
    for (int k = 0; k < exp_q.size() / L; k++) begin
      w = {exp_q[4*k+3], exp_q[4*k+2], exp_q[4*k+1], exp_q[4*k]};
      check($sformatf("rnd_data%0d", k), word_at(k), w);
      check($sformatf("rnd_count%0d", k), count_at(k), L);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
